// File: rtl/yarp_pkg.sv
// Shared yarp definitions used by the instruction fetch unit and its FIFO.
// Holds the fetch FSM state type, instruction size and the word-align helper.
package yarp_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  localparam int unsigned YARP_INSTR_BYTES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/yarp_fetch_fifo.sv
// Prefetch FIFO with a registered head entry, flush, and occupancy count.
// A push into an empty (or draining-to-empty) FIFO is visible at the head after one edge.
module yarp_fetch_fifo #(
  parameter int unsigned       DEPTH      = 4,
  parameter int unsigned       WIDTH      = 64,
  parameter logic [WIDTH-1:0]  RESET_HEAD = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CNT_FULL) || do_pop);
  assign rd_next = rd_ptr_q + 1'b1;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_next;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      // The head register takes the incoming word when nothing older remains behind it.
      if (do_push && ((cnt_q == '0) || (do_pop && (cnt_q == CNT_ONE)))) begin
        head_d = push_data_i;
      end else if (do_pop && (cnt_q > CNT_ONE)) begin
        head_d = mem_q[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= RESET_HEAD;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/yarp_instr_fetch.sv
// Instruction fetch unit: sequential fetch over a req/gnt memory port, prefetch FIFO
// toward decode, and redirect handling that discards in-flight responses.
// Handshakes: mem side transfers a request when mem_req_o && mem_gnt_i (request held
// stable until then); decode side transfers when instr_valid_o && instr_ready_i.
module yarp_instr_fetch
  import yarp_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      redirect_i,
  input  logic [31:0]               redirect_pc_i,
  output logic                      mem_req_o,
  output logic [31:0]               mem_addr_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [31:0]               mem_rd_data_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [31:0]               instr_o,
  output logic [31:0]               instr_pc_o,
  output fetch_state_t              dbg_state_o,
  output logic [$clog2(DEPTH):0]    dbg_outstanding_o,
  output logic [$clog2(DEPTH)+1:0]  dbg_discard_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = AW + 2;
  localparam logic [CW:0]   INFLIGHT_MAX = (CW+1)'(DEPTH);
  // Back-to-back redirects can pile up discards beyond DEPTH; issue pauses while it is deep.
  localparam logic [DW-1:0] DISC_ISSUE_LIMIT = DW'(2 * DEPTH);
  localparam logic [31:0]   PC_STEP = 32'(YARP_INSTR_BYTES);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d, hold_pc_q, hold_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [DW-1:0] disc_q, disc_d;
  logic          started_q;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   inflight;
  logic [31:0]   redir_pc;
  logic          gnt_fire, resp_drop, resp_keep, fifo_push, fifo_pop;
  logic [63:0]   fifo_head;

  assign redir_pc  = word_align(redirect_pc_i);
  assign inflight  = {1'b0, fifo_cnt} + {1'b0, out_q};
  assign gnt_fire  = mem_req_o && mem_gnt_i;
  assign resp_drop = mem_rvalid_i && (disc_q != '0);
  assign resp_keep = mem_rvalid_i && (disc_q == '0);
  assign fifo_push = resp_keep && !redirect_i && (state_q == RUN);
  assign fifo_pop  = instr_valid_o && instr_ready_i;

  // Request depends only on registered state; HOLD keeps the stale request up until granted.
  always_comb begin
    mem_req_o = 1'b0;
    if (started_q) begin
      if (state_q == HOLD) mem_req_o = 1'b1;
      else mem_req_o = (inflight < INFLIGHT_MAX) && (disc_q < DISC_ISSUE_LIMIT);
    end
  end

  assign mem_addr_o = fpc_q;

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    rpc_d     = rpc_q;
    hold_pc_d = hold_pc_q;
    out_d     = out_q;
    disc_d    = disc_q;
    unique case (state_q)
      RUN: begin
        if (redirect_i) begin
          // Everything issued and not yet answered (including this cycle's grant) becomes stale.
          disc_d = disc_q + DW'(out_q) + DW'(gnt_fire) - DW'(mem_rvalid_i);
          out_d  = '0;
          rpc_d  = redir_pc;
          if (mem_req_o && !mem_gnt_i) begin
            state_d   = HOLD;
            hold_pc_d = redir_pc;
          end else begin
            fpc_d = redir_pc;
          end
        end else begin
          if (gnt_fire)  fpc_d  = fpc_q + PC_STEP;
          if (resp_drop) disc_d = disc_q - DW'(1);
          if (resp_keep) rpc_d  = rpc_q + PC_STEP;
          out_d = out_q + CW'(gnt_fire) - CW'(resp_keep);
        end
      end
      HOLD: begin
        disc_d = disc_q + DW'(out_q) + DW'(gnt_fire) - DW'(mem_rvalid_i);
        out_d  = '0;
        if (redirect_i) hold_pc_d = redir_pc;
        if (gnt_fire) begin
          state_d = RUN;
          fpc_d   = redirect_i ? redir_pc : hold_pc_q;
          rpc_d   = redirect_i ? redir_pc : hold_pc_q;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      started_q <= 1'b0;
      fpc_q     <= word_align(RESET_PC);
      rpc_q     <= word_align(RESET_PC);
      hold_pc_q <= word_align(RESET_PC);
      out_q     <= '0;
      disc_q    <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      fpc_q     <= fpc_d;
      rpc_q     <= rpc_d;
      hold_pc_q <= hold_pc_d;
      out_q     <= out_d;
      disc_q    <= disc_d;
    end
  end

  yarp_fetch_fifo #(
    .DEPTH      (DEPTH),
    .WIDTH      (64),
    .RESET_HEAD ({32'h0, RESET_PC})
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (fifo_push),
    .push_data_i ({mem_rd_data_i, rpc_q}),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_i),
    .head_o      (fifo_head),
    .valid_o     (instr_valid_o),
    .count_o     (fifo_cnt)
  );

  assign instr_o           = fifo_head[63:32];
  assign instr_pc_o        = fifo_head[31:0];
  assign dbg_state_o       = state_q;
  assign dbg_outstanding_o = out_q;
  assign dbg_discard_o     = disc_q;

endmodule

// File: tb/tb_yarp_instr_fetch.sv
// Directed and randomized bench for yarp_instr_fetch with a transaction-level memory
// model and an expected-PC scoreboard.
module tb_yarp_instr_fetch;
  import yarp_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DMASK    = 32'hA5A5_0000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         redirect_i;
  logic [31:0]  redirect_pc_i;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rd_data_i;
  logic         instr_valid_o;
  logic         instr_ready_i;
  logic [31:0]  instr_o;
  logic [31:0]  instr_pc_o;
  fetch_state_t dbg_state_o;
  logic [$clog2(DEPTH):0]   dbg_outstanding_o;
  logic [$clog2(DEPTH)+1:0] dbg_discard_o;

  yarp_instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .mem_req_o         (mem_req_o),
    .mem_addr_o        (mem_addr_o),
    .mem_gnt_i         (mem_gnt_i),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_rd_data_i     (mem_rd_data_i),
    .instr_valid_o     (instr_valid_o),
    .instr_ready_i     (instr_ready_i),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o),
    .dbg_state_o       (dbg_state_o),
    .dbg_outstanding_o (dbg_outstanding_o),
    .dbg_discard_o     (dbg_discard_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus knobs and memory model state
  int unsigned gnt_pct, rdy_pct, lat_lo, lat_hi;
  int          cyc;
  logic [31:0] pa_q[$];
  int          pd_q[$];
  int          last_due;
  int          n_gnt, n_pop;
  logic [31:0] gnt_log[$];
  logic        redir_pend;
  logic [31:0] redir_pc;
  logic        prev_pend;
  logic [31:0] prev_addr;

  // Scoreboard: next PC decode must see
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},    64'(mem_req_o),         64'd0);
    chk({tag, "_addr"},   64'(mem_addr_o),        64'(RESET_PC));
    chk({tag, "_valid"},  64'(instr_valid_o),     64'd0);
    chk({tag, "_instr"},  64'(instr_o),           64'd0);
    chk({tag, "_pc"},     64'(instr_pc_o),        64'(RESET_PC));
    chk({tag, "_state"},  64'(dbg_state_o),       64'(RUN));
    chk({tag, "_outst"},  64'(dbg_outstanding_o), 64'd0);
    chk({tag, "_disc"},   64'(dbg_discard_o),     64'd0);
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rd_data_i = '0;
    instr_ready_i = 1'b0;
    redir_pend    = 1'b0;
    redir_pc      = '0;
    pa_q.delete();
    pd_q.delete();
    gnt_log.delete();
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    last_due  = 0;
    prev_pend = 1'b0;
    prev_addr = '0;
    n_gnt     = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  // One cycle: memory model, decode model, scoreboard, then advance past the edge.
  task automatic tick();
    logic        gnt, rv, rdy;
    logic [31:0] rdat, nxt;
    int          due;
    if (prev_pend) begin
      chk("req_hold",  64'(mem_req_o),  64'd1);
      chk("addr_hold", 64'(mem_addr_o), 64'(prev_addr));
    end
    chk("outst_le_depth", 64'(32'(dbg_outstanding_o) <= DEPTH), 64'd1);
    rv   = 1'b0;
    rdat = '0;
    if (pd_q.size() > 0 && pd_q[0] <= cyc) begin
      rv   = 1'b1;
      rdat = pa_q.pop_front() ^ DMASK;
      void'(pd_q.pop_front());
    end
    gnt = mem_req_o && ($urandom_range(0, 99) < gnt_pct);
    if (gnt) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pa_q.push_back(mem_addr_o);
      pd_q.push_back(due);
      gnt_log.push_back(mem_addr_o);
      n_gnt++;
    end
    rdy = ($urandom_range(0, 99) < rdy_pct);
    if (instr_valid_o && rdy) begin
      chk("pop_pc",   64'(instr_pc_o), 64'(exp_q[0]));
      chk("pop_data", 64'(instr_o),    64'(exp_q[0] ^ DMASK));
      n_pop++;
      nxt = exp_q.pop_front();
      if (!redir_pend) exp_q.push_back(nxt + 32'd4);
    end
    if (redir_pend) begin
      exp_q.delete();
      exp_q.push_back(redir_pc & ~32'h3);
    end
    prev_pend = mem_req_o && !gnt;
    prev_addr = mem_addr_o;
    mem_gnt_i     = gnt;
    mem_rvalid_i  = rv;
    mem_rd_data_i = rdat;
    instr_ready_i = rdy;
    redirect_i    = redir_pend;
    redirect_pc_i = redir_pc;
    @(posedge clk);
    #1;
    cyc++;
    redirect_i = 1'b0;
    redir_pend = 1'b0;
  endtask

  initial begin
    // Reset values
    reset_n       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rd_data_i = '0;
    instr_ready_i = 1'b0;
    n_pop         = 0;
    #12;
    check_reset_outputs("rst");

    // Streaming: grant every cycle, latency 1, decode always ready
    do_reset();
    gnt_pct = 100; rdy_pct = 100; lat_lo = 1; lat_hi = 1;
    chk("t1_req_c0", 64'(mem_req_o), 64'd0);
    tick();
    chk("t1_req_c1",  64'(mem_req_o),  64'd1);
    chk("t1_addr_c1", 64'(mem_addr_o), 64'(RESET_PC));
    tick();
    chk("t1_valid_c2", 64'(instr_valid_o), 64'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t1_valid", 64'(instr_valid_o), 64'd1);
      chk("t1_pc",    64'(instr_pc_o),    64'(32'(4 * i)));
      tick();
    end

    // Decode stalled: FIFO fills, issue stops, then drains back-to-back
    do_reset();
    gnt_pct = 100; rdy_pct = 0; lat_lo = 1; lat_hi = 1;
    repeat (20) tick();
    chk("t2_grants",  64'(n_gnt),         64'd4);
    chk("t2_req_off", 64'(mem_req_o),     64'd0);
    chk("t2_valid",   64'(instr_valid_o), 64'd1);
    rdy_pct = 100;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_valid", 64'(instr_valid_o), 64'd1);
      chk("t2_drain_pc",    64'(instr_pc_o),    64'(32'(4 * i)));
      tick();
    end
    chk("t2_resume_cnt", 64'(gnt_log.size() >= 5), 64'd1);
    if (gnt_log.size() >= 5) chk("t2_resume_addr", 64'(gnt_log[4]), 64'h10);

    // Redirect in RUN with requests in flight (latency 5)
    do_reset();
    gnt_pct = 100; rdy_pct = 100; lat_lo = 5; lat_hi = 5;
    tick(); tick(); tick();
    redir_pend = 1'b1; redir_pc = 32'h0000_1003;
    tick();
    chk("t3_req",  64'(mem_req_o),     64'd1);
    chk("t3_addr", 64'(mem_addr_o),    64'h1000);
    chk("t3_disc", 64'(dbg_discard_o), 64'd3);
    for (int i = 0; i < 40 && !instr_valid_o; i++) tick();
    chk("t3_first_valid", 64'(instr_valid_o), 64'd1);
    chk("t3_first_pc",    64'(instr_pc_o),    64'h1000);
    repeat (6) tick();

    // Redirect while the request is stuck ungranted
    do_reset();
    gnt_pct = 0; rdy_pct = 100; lat_lo = 1; lat_hi = 1;
    tick();
    chk("t4_req_c1",  64'(mem_req_o),  64'd1);
    chk("t4_addr_c1", 64'(mem_addr_o), 64'd0);
    tick();
    redir_pend = 1'b1; redir_pc = 32'h0000_0200;
    tick();
    chk("t4_state_hold", 64'(dbg_state_o), 64'(HOLD));
    chk("t4_addr_c3",    64'(mem_addr_o),  64'd0);
    tick();
    chk("t4_addr_c4", 64'(mem_addr_o), 64'd0);
    tick();
    chk("t4_addr_c5", 64'(mem_addr_o), 64'd0);
    gnt_pct = 100;
    tick();
    chk("t4_state_run", 64'(dbg_state_o), 64'(RUN));
    chk("t4_req_new",   64'(mem_req_o),   64'd1);
    chk("t4_addr_new",  64'(mem_addr_o),  64'h200);
    for (int i = 0; i < 40 && !instr_valid_o; i++) tick();
    chk("t4_first_valid", 64'(instr_valid_o), 64'd1);
    chk("t4_first_pc",    64'(instr_pc_o),    64'h200);
    repeat (6) tick();

    // Random grants, latencies, ready and redirects
    do_reset();
    gnt_pct = 70; rdy_pct = 60; lat_lo = 1; lat_hi = 6;
    n_pop = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        redir_pend = 1'b1;
        redir_pc   = $urandom;
      end
      tick();
    end
    chk("t5_progress", 64'(n_pop > 1000), 64'd1);

    // Asynchronous reset with 2 outstanding and 2 buffered
    do_reset();
    gnt_pct = 100; rdy_pct = 0; lat_lo = 3; lat_hi = 3;
    repeat (6) tick();
    chk("t6_outst_pre", 64'(dbg_outstanding_o), 64'd2);
    chk("t6_valid_pre", 64'(instr_valid_o),     64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    do_reset();
    gnt_pct = 100; rdy_pct = 100; lat_lo = 1; lat_hi = 1;
    chk("t6_req_c0", 64'(mem_req_o), 64'd0);
    tick();
    chk("t6_req_c1",  64'(mem_req_o),  64'd1);
    chk("t6_addr_c1", 64'(mem_addr_o), 64'(RESET_PC));
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
